// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store unit: FSM state encoding, RV32I
// funct3 width codes, timeout counter sizing and request legality helpers.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned access trapping).
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W_DEFAULT   = $clog2(TIMEOUT_DEFAULT + 1);

  // Width of a counter able to hold 0..timeout inclusive.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Unsigned loads have no store counterpart, so 100/101 are illegal for stores.
  function automatic logic code_legal(input logic write, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !write;
      default:          return 1'b0;
    endcase
  endfunction

  // funct3[1:0] encodes the access size for both signed and unsigned codes.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align
// Combinational lane logic shared by the request and response paths.
// Ports:
//   write, funct3, addr_lo : access kind and low address bits
//   wdata                  : LSB-justified store data
//   mem_rdata              : raw memory word for loads
//   be, lanes              : byte enables and lane-replicated store data
//   load_data              : extracted and sign/zero-extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] lanes,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Stores replicate the datum across every lane so the memory only needs
  // the byte enables; loads always read the full word.
  always_comb begin
    be    = 4'b1111;
    lanes = wdata;
    if (write) begin
      case (funct3[1:0])
        2'b00: begin
          lanes = {4{wdata[7:0]}};
          be    = 4'b0001 << addr_lo;
        end
        2'b01: begin
          lanes = {2{wdata[15:0]}};
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          lanes = wdata;
          be    = 4'b1111;
        end
      endcase
    end
  end

  // Halfword lane selection ignores addr[0] so misaligned halfwords read the
  // containing aligned half when trapping is disabled.
  always_comb begin
    byte_lane = mem_rdata[7:0];
    case (addr_lo)
      2'b00: byte_lane = mem_rdata[7:0];
      2'b01: byte_lane = mem_rdata[15:8];
      2'b10: byte_lane = mem_rdata[23:16];
      2'b11: byte_lane = mem_rdata[31:24];
      default: byte_lane = mem_rdata[7:0];
    endcase
    half_lane = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_BU:   load_data = {24'd0, byte_lane};
      F3_HU:   load_data = {16'd0, half_lane};
      default: load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Multi-cycle RV32I data-memory access unit. Takes one load/store request,
// runs a req/ack transaction on the data-memory port, and returns the
// extended load result on rdata with a one-cycle done pulse.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, write,
//   funct3, addr, wdata : request (sampled only in IDLE)
//   busy, done, error   : status; error qualifies done
//   rdata, mem_drive    : load result and bus-drive strobe
//   mem_*               : data-memory request/response port
// Parameter TIMEOUT_CYCLES (1..65535): WAIT cycles allowed before abort.
// Optional feature macro: LSU_MISALIGN_TRAP_EN traps misaligned half/word
// accesses with error instead of issuing them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] rdata,
  output logic        mem_drive,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             write_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;

  logic             sel_write;
  logic [2:0]       sel_funct3;
  logic [1:0]       sel_addr_lo;
  logic [3:0]       al_be;
  logic [31:0]      al_lanes;
  logic [31:0]      al_load;
  logic             req_ok;

  assign busy = (state != IDLE);

  // The aligner sees the live request while idle and the captured request
  // afterwards, so one instance serves both the store and load paths.
  assign sel_write   = (state == IDLE) ? write         : write_q;
  assign sel_funct3  = (state == IDLE) ? funct3        : funct3_q;
  assign sel_addr_lo = (state == IDLE) ? addr[1:0]     : addr_lo_q;

  lsu_align u_align (
    .write     (sel_write),
    .funct3    (sel_funct3),
    .addr_lo   (sel_addr_lo),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .be        (al_be),
    .lanes     (al_lanes),
    .load_data (al_load)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_ok = code_legal(write, funct3) && !misaligned(funct3, addr[1:0]);
`else
  assign req_ok = code_legal(write, funct3);
`endif

  // Ack is checked before the timeout limit so a late ack still completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      write_q   <= 1'b0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      done      <= 1'b0;
      error     <= 1'b0;
      rdata     <= 32'd0;
      mem_drive <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'd0;
    end else begin
      done      <= 1'b0;
      error     <= 1'b0;
      mem_drive <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            write_q   <= write;
            funct3_q  <= funct3;
            addr_lo_q <= addr[1:0];
            cnt       <= '0;
            if (req_ok) begin
              state     <= WAIT;
              mem_req   <= 1'b1;
              mem_we    <= write;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= al_be;
              mem_wdata <= al_lanes;
            end else begin
              state <= RESP;
              done  <= 1'b1;
              error <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (mem_ack || cnt == CNT_LAST) begin
            state     <= RESP;
            done      <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'd0;
            if (!mem_ack) begin
              error <= 1'b1;
            end else if (!write_q) begin
              rdata     <= al_load;
              mem_drive <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Directed, table-driven bench for load_store_unit (TIMEOUT_CYCLES = 4),
// plus hand-written reset and mid-access reset sequences.
// Expectations for the misaligned word load follow LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] rdata;
  logic        mem_drive;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    int          ack_wait;
    logic        issue;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .write     (write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .rdata     (rdata),
    .mem_drive (mem_drive),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] mr, input int aw,
                              input logic iss, input logic er, input logic [3:0] be,
                              input logic [31:0] ewd, input logic [31:0] erd);
    vec_t v;
    v.write = w; v.funct3 = f3; v.addr = a; v.wdata = wd; v.mem_rdata = mr;
    v.ack_wait = aw; v.issue = iss; v.exp_err = er; v.exp_be = be;
    v.exp_wdata = ewd; v.exp_rdata = erd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one request, plays the memory side, and checks the whole response.
  task automatic applyStimulus(input vec_t v, input int idx);
    int waits;
    int exp_waits;
    string t;
    t = $sformatf("v%0d", idx);
    start = 1'b1; write = v.write; funct3 = v.funct3; addr = v.addr; wdata = v.wdata;
    @(posedge clk); #1;
    start = 1'b0;
    if (v.issue) begin
      checkOutput({t, "_mem_req"}, mem_req, 1);
      checkOutput({t, "_mem_we"}, mem_we, v.write);
      checkOutput({t, "_mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
      checkOutput({t, "_mem_be"}, mem_be, v.exp_be);
      if (v.write) checkOutput({t, "_mem_wdata"}, mem_wdata, v.exp_wdata);
      waits = 0;
      while (!done && waits < 20) begin
        mem_rdata = v.mem_rdata;
        mem_ack = (v.ack_wait >= 0 && waits == v.ack_wait);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        waits++;
      end
      exp_waits = (v.ack_wait >= 0) ? v.ack_wait + 1 : TMO;
      checkOutput({t, "_latency"}, waits, exp_waits);
    end
    checkOutput({t, "_done"}, done, 1);
    checkOutput({t, "_error"}, error, v.exp_err);
    checkOutput({t, "_mem_drive"}, mem_drive, !v.write && !v.exp_err);
    checkOutput({t, "_rdata"}, rdata, v.exp_rdata);
    checkOutput({t, "_req_off"}, mem_req, 0);
    checkOutput({t, "_busy_resp"}, busy, 1);
    @(posedge clk); #1;
    checkOutput({t, "_done_clr"}, done, 0);
    checkOutput({t, "_busy_clr"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back(mk(0, F3_W,  32'h100, 0, 32'hDEADBEEF, 0, 1, 0, 4'hF, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, F3_B,  32'h103, 0, 32'h80FF0000, 0, 1, 0, 4'hF, 0, 32'hFFFFFF80));
    vecs.push_back(mk(0, F3_BU, 32'h103, 0, 32'h80FF0000, 0, 1, 0, 4'hF, 0, 32'h00000080));
    vecs.push_back(mk(1, F3_H,  32'h102, 32'h1234ABCD, 0, 0, 1, 0, 4'hC, 32'hABCDABCD, 32'h00000080));
    vecs.push_back(mk(1, F3_B,  32'h101, 32'h000000A5, 0, 1, 1, 0, 4'h2, 32'hA5A5A5A5, 32'h00000080));
    vecs.push_back(mk(0, F3_H,  32'h102, 0, 32'h80017FFF, 0, 1, 0, 4'hF, 0, 32'hFFFF8001));
    vecs.push_back(mk(0, F3_HU, 32'h100, 0, 32'h8001F00F, 0, 1, 0, 4'hF, 0, 32'h0000F00F));
    vecs.push_back(mk(1, F3_W,  32'h200, 32'hCAFEF00D, 0, 0, 1, 0, 4'hF, 32'hCAFEF00D, 32'h0000F00F));
    vecs.push_back(mk(0, 3'b011, 32'h100, 0, 0, 0, 0, 1, 4'hF, 0, 32'h0000F00F));
    vecs.push_back(mk(1, F3_BU, 32'h100, 32'h11, 0, 0, 0, 1, 4'hF, 0, 32'h0000F00F));
    vecs.push_back(mk(0, F3_W,  32'h104, 0, 32'h99999999, -1, 1, 1, 4'hF, 0, 32'h0000F00F));
    vecs.push_back(mk(0, F3_W,  32'h104, 0, 32'h11223344, 0, 1, 0, 4'hF, 0, 32'h11223344));
    vecs.push_back(mk(0, F3_B,  32'h101, 0, 32'h00007F00, TMO - 1, 1, 0, 4'hF, 0, 32'h0000007F));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, F3_W,  32'h102, 0, 32'h55667788, 0, 0, 1, 4'hF, 0, 32'h0000007F));
`else
    vecs.push_back(mk(0, F3_W,  32'h102, 0, 32'h55667788, 0, 1, 0, 4'hF, 0, 32'h55667788));
`endif

    rst = 1'b1; start = 1'b0; write = 1'b0; funct3 = 3'b000; addr = 32'd0; wdata = 32'd0;
    mem_rdata = 32'd0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_error", error, 0);
    checkOutput("reset_rdata", rdata, 0);
    checkOutput("reset_mem_req", mem_req, 0);
    checkOutput("reset_mem_be", mem_be, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // Reset in the second WAIT cycle, then a stale ack alongside a new start.
    start = 1'b1; write = 1'b0; funct3 = F3_W; addr = 32'h300;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_pre_req", mem_req, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_req", mem_req, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hA5A51234;
    start = 1'b1; write = 1'b0; funct3 = F3_W; addr = 32'h300;
    @(posedge clk); #1;
    mem_ack = 1'b0; start = 1'b0;
    checkOutput("rst_stale_done", done, 0);
    checkOutput("rst_stale_rdata", rdata, 0);
    checkOutput("rst_restart_busy", busy, 1);
    checkOutput("rst_restart_req", mem_req, 1);
    checkOutput("rst_restart_addr", mem_addr, 32'h300);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkOutput("rst_restart_done", done, 1);
    checkOutput("rst_restart_rdata", rdata, 32'h0BADF00D);
    @(posedge clk); #1;
    checkOutput("rst_restart_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access unit for the RV32I core. Accepts a single load or store request, drives a req/ack data-memory port with byte enables and aligned data, then returns the sign- or zero-extended load result. The result drives the main bus memory source (`rdata` to `memory_in`, `mem_drive` to the `memory` select), so the bus picks it up in the completion cycle.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles spent waiting for `mem_ack` before the access aborts with an error; range 1..65535.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `start` in 1: request strobe; sampled only in IDLE.
- `write` in 1: 1 = store, 0 = load.
- `funct3` in 3: RV32I width code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `addr` in 32: byte address.
- `wdata` in 32: store data, LSB-justified and unshifted.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: qualifies `done`; set on an illegal code, a misaligned access or a timeout.
- `rdata` out 32: extended load result; holds its value until the next successful load.
- `mem_drive` out 1: high only in the `done` cycle of a successful load.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32 (bits [1:0] always 0), `mem_be` out 4, `mem_wdata` out 32: data-memory request, held stable while `mem_req` is high.
- `mem_rdata` in 32, `mem_ack` in 1: memory response; valid in the cycle `mem_ack` is high.

## Operation
- FSM states:
  - IDLE: accepts `start`.
  - WAIT: `mem_req` is high.
  - RESP: `done` is high.
- IDLE with `start`:
  - Captures the request.
  - Goes to WAIT if the access is legal, otherwise to RESP with `error`=1 and no `mem_req` issued.
  - Illegal codes: 011, 110, 111 for any access; 100 and 101 for stores.
- WAIT:
  - `mem_ack` → capture and extend `mem_rdata`, go to RESP.
  - Counter reaches `TIMEOUT_CYCLES` without ack → RESP with `error`=1, `rdata` unchanged.
  - Ack in the same cycle the limit is reached: ack wins.
- RESP: goes to IDLE unconditionally.
- Store lane placement:
  - Byte: `wdata[7:0]` replicated to all four lanes, `mem_be` = 1 << addr[1:0].
  - Half: `wdata[15:0]` replicated to both halves, `mem_be` = 0011 or 1100 selected by addr[1].
  - Word: `mem_be` = 1111.
- Loads:
  - `mem_be` = 1111 and `mem_we` = 0.
  - The selected lane is extracted by the low address bits, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- `start` while `busy` is ignored and not queued.
- Reset values: FSM IDLE; `rdata` 0; all other outputs 0; timeout counter 0.

## Timing
- `start` sampled at edge N; `mem_req` high from N+1 (registered).
- `mem_ack` sampled high at edge M gives `done` high for the cycle after M. Minimum latency (ack in first WAIT cycle) is 2 cycles from `start` to `done`.
- An illegal or misaligned request gives `done` 1 cycle after `start`.
- `mem_req` drops in the cycle after ack.
- Reset mid-access: all outputs clear immediately (asynchronous). A memory ack arriving after reset is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with addr[0]=1 → error.
  - LW/SW with addr[1:0]≠0 → error.
  - In both cases no memory access is issued.
- Undefined:
  - Misaligned accesses proceed without error.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].

## Structure
- `lsu_pkg`: state enum (IDLE, WAIT, RESP), funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), and the counter-width localparam derived via `$clog2(TIMEOUT_CYCLES+1)`.
- Sub-module `lsu_align` (combinational): store lane replication and `mem_be` generation, plus load lane extraction and extension. Shared by the request and response paths.
- Top level: FSM, request and response registers, timeout counter.

## Test plan
- LW addr 0x100, memory returns 0xDEADBEEF with ack in the first WAIT cycle → `done` and `mem_drive` 2 cycles after `start`, `rdata`=0xDEADBEEF, `mem_be`=1111.
- LB at 0x103 and LBU at 0x103, `mem_rdata`=0x80FF_0000 → `rdata`=0xFFFFFF80 (LB) and 0x00000080 (LBU).
- SH addr 0x102, `wdata`=0x1234ABCD → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_addr`=0x100; `done` with `mem_drive`=0.
- `TIMEOUT_CYCLES`=4, ack never asserted → `done` and `error` after 4 WAIT cycles, `rdata` unchanged; a follow-up LW succeeds normally.
- LW at 0x102 → error pulse 1 cycle after `start` and no `mem_req` with the macro defined; normal access to 0x100 without it.
- `rst` pulsed in the second WAIT cycle, then ack arrives → `mem_req`, `busy` and `done` stay 0, `rdata`=0; `start` is accepted in the cycle after reset release.
